// File: rtl/stream_pattern_source.sv
// Ready/valid pattern transmitter: emits a burst of arithmetic-sequence beats with optional idle gaps.
// Optional macro STREAM_PATTERN_SOURCE_LFSR_EN adds i_lfsr_mode (Galois LFSR data, taps 0xB8).
module stream_pattern_source #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned GAP_WIDTH   = 4
) (
  input  logic                   i_clock,
  input  logic                   i_nreset,
  input  logic                   i_start,
  input  logic [DATA_WIDTH-1:0]  i_start_value,
  input  logic [DATA_WIDTH-1:0]  i_step,
  input  logic [COUNT_WIDTH-1:0] i_count,
  input  logic [GAP_WIDTH-1:0]   i_gap,
`ifdef STREAM_PATTERN_SOURCE_LFSR_EN
  input  logic                   i_lfsr_mode,
`endif
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [COUNT_WIDTH-1:0] o_beats_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  step_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [GAP_WIDTH-1:0]   gap_q;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [DATA_WIDTH-1:0]  next_data;
  logic [DATA_WIDTH-1:0]  first_data;
  logic                   transfer;
  logic                   last_beat;

  assign transfer  = o_valid && i_ready;
  assign last_beat = (o_beats_sent + COUNT_WIDTH'(1)) == count_q;

`ifdef STREAM_PATTERN_SOURCE_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(8'hB8);

  logic                  lfsr_q;
  logic [DATA_WIDTH-1:0] lfsr_next;

  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      lfsr_q <= 1'b0;
    end else if (state == IDLE && i_start) begin
      lfsr_q <= i_lfsr_mode;
    end
  end

  always_comb begin
    lfsr_next = (o_data >> 1) ^ (o_data[0] ? LFSR_TAPS : '0);
    next_data = lfsr_q ? lfsr_next : o_data + step_q;
    // An all-zero LFSR state would lock, so a zero seed is promoted to 1.
    first_data = (i_lfsr_mode && i_start_value == '0) ? DATA_WIDTH'(1) : i_start_value;
  end
`else
  always_comb begin
    next_data  = o_data + step_q;
    first_data = i_start_value;
  end
`endif

  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      state        <= IDLE;
      step_q       <= '0;
      count_q      <= '0;
      gap_q        <= '0;
      gap_cnt      <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_beats_sent <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            step_q       <= i_step;
            count_q      <= i_count;
            gap_q        <= i_gap;
            o_beats_sent <= '0;
            if (i_count != '0) begin
              o_data  <= first_data;
              o_valid <= 1'b1;
              o_busy  <= 1'b1;
              state   <= SEND;
            end else begin
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end
        SEND: begin
          if (transfer) begin
            o_beats_sent <= o_beats_sent + COUNT_WIDTH'(1);
            if (last_beat) begin
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              state   <= DONE;
            end else if (gap_q == '0) begin
              o_data <= next_data;
            end else begin
              o_valid <= 1'b0;
              gap_cnt <= gap_q;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          // gap_cnt holds the remaining low cycles including the current one.
          if (gap_cnt == GAP_WIDTH'(1)) begin
            o_data  <= next_data;
            o_valid <= 1'b1;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pattern_source.sv
// Self-checking bench for stream_pattern_source: table of bursts plus reset-abort sequence,
// checked against a sequence model computed directly from start/step/count/gap.
module tb_stream_pattern_source;

  logic       i_clock = 1'b0;
  logic       i_nreset;
  logic       i_start;
  logic [7:0] i_start_value;
  logic [7:0] i_step;
  logic [7:0] i_count;
  logic [3:0] i_gap;
  logic       i_lfsr_mode;
  logic       i_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_beats_sent;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 i_clock = ~i_clock;

  stream_pattern_source #(
    .DATA_WIDTH(8),
    .COUNT_WIDTH(8),
    .GAP_WIDTH(4)
  ) dut (
    .i_clock(i_clock),
    .i_nreset(i_nreset),
    .i_start(i_start),
    .i_start_value(i_start_value),
    .i_step(i_step),
    .i_count(i_count),
    .i_gap(i_gap),
`ifdef STREAM_PATTERN_SOURCE_LFSR_EN
    .i_lfsr_mode(i_lfsr_mode),
`endif
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_beats_sent(o_beats_sent)
  );

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1 repeating, 2 random, 3 mostly ready
  typedef struct {
    logic [7:0] sv;
    logic [7:0] step;
    logic [7:0] cnt;
    logic [3:0] gap;
    logic       lfsr;
    int         ready_mode;
    logic [7:0] exp_last;
  } burst_t;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_beats"}, o_beats_sent, 0);
  endtask

  task automatic run_burst(input burst_t b);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  v;
    logic        r;
    logic        prev_valid;
    logic        prev_ready;
    logic [7:0]  prev_data;
    logic        pend_gap;
    logic        seen_done;
    int unsigned gap_run;
    int unsigned cycles;

    // Expected beats: k-th beat is start + k*step, or the k-th LFSR successor of the seed.
    v = (b.lfsr && b.sv == 8'h00) ? 8'h01 : b.sv;
    for (int k = 0; k < int'(b.cnt); k++) begin
      if (b.lfsr) begin
        exp_q.push_back(v);
        v = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
      end else begin
        exp_q.push_back(8'(int'(b.sv) + k * int'(b.step)));
      end
    end

    @(negedge i_clock);
    chk("idle_busy", o_busy, 0);
    i_start       = 1'b1;
    i_start_value = b.sv;
    i_step        = b.step;
    i_count       = b.cnt;
    i_gap         = b.gap;
    i_lfsr_mode   = b.lfsr;
    i_ready       = 1'b0;

    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    pend_gap   = 1'b0;
    seen_done  = 1'b0;
    gap_run    = 0;
    cycles     = 0;

    while (!seen_done && cycles < 2000) begin
      @(negedge i_clock);
      cycles++;
      if (cycles == 1) begin
        chk("first_valid", o_valid, (b.cnt != 0) ? 1 : 0);
        chk("first_busy", o_busy, (b.cnt != 0) ? 1 : 0);
        if (b.cnt != 0) chk("first_data", o_data, exp_q[0]);
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, prev_data);
      end
      if (o_valid) chk("busy_while_valid", o_busy, 1);
      if (pend_gap) begin
        if (o_valid) begin
          chk("gap_len", gap_run, b.gap);
          pend_gap = 1'b0;
        end else begin
          gap_run++;
        end
      end
      if (o_done) begin
        seen_done = 1'b1;
        i_start   = 1'b0;
        chk("done_busy", o_busy, 0);
        chk("done_valid", o_valid, 0);
        chk("done_beats", o_beats_sent, b.cnt);
        @(negedge i_clock);
        chk("done_pulse_width", o_done, 0);
        chk("beats_hold", o_beats_sent, b.cnt);
        chk("idle_valid", o_valid, 0);
      end else begin
        case (b.ready_mode)
          0:       r = 1'b1;
          1:       r = ((cycles - 1) % 4 == 0) || ((cycles - 1) % 4 == 3);
          2:       r = 1'($urandom_range(0, 1));
          default: r = ($urandom_range(0, 3) != 0);
        endcase
        i_ready = r;
        if (o_valid && r) begin
          got_q.push_back(o_data);
          if (got_q.size() < int'(b.cnt)) begin
            pend_gap = 1'b1;
            gap_run  = 0;
          end
        end
        prev_valid = o_valid;
        prev_ready = r;
        prev_data  = o_data;
        // Start and configuration changes mid-burst must be ignored.
        i_start       = 1'($urandom_range(0, 1));
        i_start_value = 8'($urandom);
        i_step        = 8'($urandom);
        i_count       = 8'($urandom);
        i_gap         = 4'($urandom);
        i_lfsr_mode   = 1'($urandom_range(0, 1));
      end
    end
    i_start = 1'b0;
    i_ready = 1'b0;
    if (!seen_done) chk("done_timeout", 0, 1);

    chk("beat_count", got_q.size(), b.cnt);
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("beat_data[%0d]", k), got_q[k], exp_q[k]);
    if (b.cnt != 0 && got_q.size() != 0) chk("last_beat_data", got_q[got_q.size() - 1], b.exp_last);
  endtask

  burst_t tbl[$];
  int unsigned nsent;
  int unsigned wait_cycles;

  initial begin
    i_nreset      = 1'b0;
    i_start       = 1'b0;
    i_start_value = '0;
    i_step        = '0;
    i_count       = '0;
    i_gap         = '0;
    i_lfsr_mode   = 1'b0;
    i_ready       = 1'b1;

    //           sv     step   cnt    gap   lfsr  mode exp_last
    tbl.push_back('{8'd12,  8'd1,   8'd4,   4'd0,  1'b0, 0, 8'd15});
    tbl.push_back('{8'd12,  8'd1,   8'd4,   4'd0,  1'b0, 1, 8'd15});
    tbl.push_back('{8'hFE,  8'd1,   8'd3,   4'd2,  1'b0, 0, 8'h00});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   4'd0,  1'b0, 0, 8'd0});
    tbl.push_back('{8'd250, 8'd7,   8'd10,  4'd1,  1'b0, 2, 8'd57});
    tbl.push_back('{8'd0,   8'd255, 8'd255, 4'd0,  1'b0, 3, 8'd2});
    tbl.push_back('{8'd3,   8'd16,  8'd5,   4'd15, 1'b0, 2, 8'd67});
    tbl.push_back('{8'd200, 8'd9,   8'd1,   4'd3,  1'b0, 0, 8'd200});
`ifdef STREAM_PATTERN_SOURCE_LFSR_EN
    tbl.push_back('{8'h01,  8'd77,  8'd4,   4'd0,  1'b1, 0, 8'h2E});
    tbl.push_back('{8'h00,  8'd5,   8'd4,   4'd1,  1'b1, 2, 8'h2E});
`endif

    repeat (2) @(negedge i_clock);
    check_reset_values("reset");
    i_nreset = 1'b1;

    foreach (tbl[i]) run_burst(tbl[i]);

    // Reset asserted after two beats of an 8-beat burst aborts it immediately.
    @(negedge i_clock);
    i_start       = 1'b1;
    i_start_value = 8'd100;
    i_step        = 8'd3;
    i_count       = 8'd8;
    i_gap         = 4'd0;
    i_lfsr_mode   = 1'b0;
    i_ready       = 1'b1;
    nsent         = 0;
    wait_cycles   = 0;
    while (nsent < 2 && wait_cycles < 50) begin
      @(negedge i_clock);
      i_start = 1'b0;
      wait_cycles++;
      if (o_valid) nsent++;
    end
    if (nsent < 2) chk("abort_setup_timeout", 0, 1);
    @(negedge i_clock);
    chk("abort_prior_valid", o_valid, 1);
    i_nreset = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) @(negedge i_clock);
    chk("abort_hold_valid", o_valid, 0);
    i_nreset = 1'b1;
    run_burst('{8'd100, 8'd3, 8'd8, 4'd0, 1'b0, 0, 8'd121});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
